load_store_unit: RTL and testbench

- Sits between the MEM pipeline stage and the byte-addressed data memory. Data memory always reads and writes a full 4-byte little-endian word at a word-aligned byte address.
- Accepts one load or store request at a time and decodes RV32I funct3.
- Extracts and sign/zero-extends sub-word load data.
- Performs read-modify-write for SB/SH.
- Reports illegal, misaligned and out-of-range accesses without touching memory.

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_align.sv | 59 +++++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, types and decode helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_MISAL = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Request attributes held for the duration of one access.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } lsu_req_t;

  // Unsigned sub-word variants exist only for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misal(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational sub-word datapath: load extract/extend and store byte/half merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] store_word_c
);

  logic [BYTE_W-1:0] byte_c;
  logic [HALF_W-1:0] half_c;

  // Only the addressed lane is forwarded, so unselected bytes never reach the result.
  always_comb begin
    case (offset_i)
      2'd0:    byte_c = word_i[7:0];
      2'd1:    byte_c = word_i[15:8];
      2'd2:    byte_c = word_i[23:16];
      default: byte_c = word_i[31:24];
    endcase
    half_c = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    load_data_c = {{(XLEN-BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
      F3_BU:   load_data_c = XLEN'(byte_c);
      F3_H:    load_data_c = {{(XLEN-HALF_W){half_c[HALF_W-1]}}, half_c};
      F3_HU:   load_data_c = XLEN'(half_c);
      F3_W:    load_data_c = word_i;
      default: load_data_c = '0;
    endcase
  end

  always_comb begin
    store_word_c = word_i;
    case (funct3_i)
      F3_B: begin
        case (offset_i)
          2'd0:    store_word_c[7:0]   = wdata_i[7:0];
          2'd1:    store_word_c[15:8]  = wdata_i[7:0];
          2'd2:    store_word_c[23:16] = wdata_i[7:0];
          default: store_word_c[31:24] = wdata_i[7:0];
        endcase
      end
      F3_H: begin
        if (offset_i[1]) store_word_c[31:16] = wdata_i[15:0];
        else             store_word_c[15:0]  = wdata_i[15:0];
      end
      default: store_word_c = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the MEM stage and a word-wide data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [1:0]      rsp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned AW = XLEN + 1;

  lsu_state_e      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_err_q, rsp_err_d;

  logic [XLEN-1:0] word_addr_c;
  logic [AW-1:0]   last_byte_c;
  logic [1:0]      req_err_c;
  logic [XLEN-1:0] load_data_c;
  logic [XLEN-1:0] store_word_c;

  // Extra top bit keeps the last-byte sum from wrapping near the top of the address space.
  assign word_addr_c = {req_addr[XLEN-1:2], 2'b00};
  assign last_byte_c = {1'b0, word_addr_c} + AW'(3);

  always_comb begin
    req_err_c = ERR_OK;
    if (!f3_legal(req_we, req_funct3))            req_err_c = ERR_ILL;
    else if (f3_misal(req_funct3, req_addr[1:0])) req_err_c = ERR_MISAL;
    else if (last_byte_c >= AW'(MEM_BYTES))       req_err_c = ERR_RANGE;
  end

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .word_i       (mem_rdata),
    .wdata_i      (wdata_q),
    .offset_i     (req_q.off),
    .funct3_i     (req_q.funct3),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  // Strobes and response fields are decided for the state being entered, then registered.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = ERR_OK;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.we     = req_we;
          req_d.funct3 = req_funct3;
          req_d.off    = req_addr[1:0];
          wdata_d      = req_wdata;
          mem_addr_d   = word_addr_c;
          if (req_err_c != ERR_OK) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err_c;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d     = ST_WRITE;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = ST_READ;
            mem_read_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (req_q.we) begin
          state_d     = ST_WRITE;
          mem_write_d = 1'b1;
          mem_wdata_d = store_word_c;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data_c;
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 32-byte behavioural data memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_BYTES(32), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:7];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'h0102_0304;
      mem[1] <= 32'h0000_8000;
      mem[2] <= 32'h0000_0000;
      mem[3] <= 32'hCAFE_F00D;
      mem[4] <= 32'h0000_0000;
      mem[5] <= 32'h0000_0000;
      mem[6] <= 32'h0000_0000;
      mem[7] <= 32'h7777_7777;
    end else if (mem_write) begin
      mem[mem_addr[4:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[4:2]];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t rsp_q[$];
  exp_t wr_q[$];
  exp_t rd_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every strobe or response must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (mem_read || mem_write)
        chk("strobe_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      if (rsp_valid) begin
        if (rsp_q.size() == 0) fail_now("unexpected_rsp");
        else begin
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.data);
          chk("rsp_err", {30'b0, rsp_err}, {30'b0, e.err});
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      if (mem_write) begin
        if (wr_q.size() == 0) fail_now("unexpected_write");
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          chk("wr_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      if (mem_read) begin
        if (rd_q.size() == 0) fail_now("unexpected_read");
        else begin
          e = rd_q.pop_front();
          chk("rd_addr", mem_addr, e.addr);
          chk("rd_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Queue what the accepted request must produce; acc is cycle T.
  task automatic push_exp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic [31:0] exp_wword, input logic [1:0] exp_err, input int acc);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    if (exp_err != ERR_OK) begin
      rsp_q.push_back('{addr: waddr, data: 32'h0, err: exp_err, acc: acc, lat: 1});
    end else if (!we) begin
      rd_q.push_back('{addr: waddr, data: 32'h0, err: ERR_OK, acc: acc, lat: 1});
      rsp_q.push_back('{addr: waddr, data: exp_rdata, err: ERR_OK, acc: acc, lat: 2});
    end else if (f3 == F3_W) begin
      wr_q.push_back('{addr: waddr, data: wdata, err: ERR_OK, acc: acc, lat: 1});
      rsp_q.push_back('{addr: waddr, data: 32'h0, err: ERR_OK, acc: acc, lat: 2});
    end else begin
      rd_q.push_back('{addr: waddr, data: 32'h0, err: ERR_OK, acc: acc, lat: 1});
      wr_q.push_back('{addr: waddr, data: exp_wword, err: ERR_OK, acc: acc, lat: 2});
      rsp_q.push_back('{addr: waddr, data: 32'h0, err: ERR_OK, acc: acc, lat: 3});
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic [31:0] exp_wword, input logic [1:0] exp_err);
    bit ok;
    wait_ready(ok);
    if (!ok) begin
      fail_now("issue_ready_timeout");
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    push_exp(we, f3, addr, wdata, exp_rdata, exp_wword, exp_err, cyc);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, {30'b0, rsp_err}, 32'd0);
    chk({tag, "_mem_read"}, {31'b0, mem_read}, 32'd0);
    chk({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    bit ok;
    int prev;
    int acc;
    logic [31:0] a;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    // Word store then load back
    issue(1'b1, F3_W, 32'd8, 32'hDEAD_BEEF, 32'h0, 32'h0, ERR_OK);
    issue(1'b0, F3_W, 32'd8, 32'h0, 32'hDEAD_BEEF, 32'h0, ERR_OK);

    // Sub-word loads from word @4 = 0x00008000
    issue(1'b0, F3_B,  32'd5, 32'h0, 32'hFFFF_FF80, 32'h0, ERR_OK);
    issue(1'b0, F3_BU, 32'd5, 32'h0, 32'h0000_0080, 32'h0, ERR_OK);
    issue(1'b0, F3_H,  32'd4, 32'h0, 32'hFFFF_8000, 32'h0, ERR_OK);
    issue(1'b0, F3_HU, 32'd4, 32'h0, 32'h0000_8000, 32'h0, ERR_OK);
    issue(1'b0, F3_B,  32'd6, 32'h0, 32'h0000_0000, 32'h0, ERR_OK);

    // Read-modify-write stores
    issue(1'b1, F3_W, 32'd8,  32'h1122_3344, 32'h0, 32'h0, ERR_OK);
    issue(1'b1, F3_B, 32'd9,  32'hFFFF_FF5A, 32'h0, 32'h1122_5A44, ERR_OK);
    issue(1'b0, F3_W, 32'd8,  32'h0, 32'h1122_5A44, 32'h0, ERR_OK);
    issue(1'b1, F3_H, 32'd10, 32'h1234_BEEF, 32'h0, 32'hBEEF_5A44, ERR_OK);
    issue(1'b0, F3_HU, 32'd10, 32'h0, 32'h0000_BEEF, 32'h0, ERR_OK);
    issue(1'b0, F3_H,  32'd10, 32'h0, 32'hFFFF_BEEF, 32'h0, ERR_OK);

    // Top of memory and error priority
    issue(1'b0, F3_W,   32'd28, 32'h0, 32'h7777_7777, 32'h0, ERR_OK);
    issue(1'b0, F3_HU,  32'd30, 32'h0, 32'h0000_7777, 32'h0, ERR_OK);
    issue(1'b0, F3_H,   32'd3,  32'h0, 32'h0, 32'h0, ERR_MISAL);
    issue(1'b0, F3_W,   32'd32, 32'h0, 32'h0, 32'h0, ERR_RANGE);
    issue(1'b0, 3'b011, 32'd0,  32'h0, 32'h0, 32'h0, ERR_ILL);
    issue(1'b1, F3_BU,  32'd0,  32'h0, 32'h0, 32'h0, ERR_ILL);
    issue(1'b0, F3_H,   32'd33, 32'h0, 32'h0, 32'h0, ERR_MISAL);
    issue(1'b0, 3'b110, 32'd1,  32'h0, 32'h0, 32'h0, ERR_ILL);
    issue(1'b0, F3_W,   32'd30, 32'h0, 32'h0, 32'h0, ERR_MISAL);
    issue(1'b1, F3_W,   32'd32, 32'h5555_5555, 32'h0, 32'h0, ERR_RANGE);
    issue(1'b0, F3_B,   32'd32, 32'h0, 32'h0, 32'h0, ERR_RANGE);

    // Reset during the READ phase of an SH
    wait_ready(ok);
    if (!ok) fail_now("midrst_ready_timeout");
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_H;
    req_addr   = 32'd12;
    req_wdata  = 32'h0000_1234;
    rd_q.push_back('{addr: 32'd12, data: 32'h0, err: ERR_OK, acc: cyc, lat: 1});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready_after", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("midrst_mem_word", mem[3], 32'hCAFE_F00D);
    issue(1'b0, F3_W, 32'd12, 32'h0, 32'hCAFE_F00D, 32'h0, ERR_OK);

    // Request held continuously: one accept every 3 cycles, responses in order
    prev = -1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    for (int k = 0; k < 6; k++) begin
      a = (k % 2 == 1) ? 32'd4 : 32'd0;
      req_addr = a;
      wait_ready(ok);
      if (!ok) begin
        fail_now("b2b_ready_timeout");
        break;
      end
      acc = cyc;
      push_exp(1'b0, F3_W, a, 32'h0, (k % 2 == 1) ? 32'h0000_8000 : 32'h0102_0304,
               32'h0, ERR_OK, acc);
      if (prev >= 0) chk("b2b_accept_spacing", 32'(acc - prev), 32'd3);
      prev = acc;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;

    for (int i = 0; i < 50; i++) begin
      if (rsp_q.size() == 0 && wr_q.size() == 0 && rd_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
    chk("drain_wr_q", 32'(wr_q.size()), 32'd0);
    chk("drain_rd_q", 32'(rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
